// File: rtl/ring_request_agent.sv
// Requester-side endpoint of the packet ring: injects one outstanding request into an empty
// (or stale-response) slot, removes its own response, and reports it to the core as a pulse.
module ring_request_agent #(
  parameter int unsigned DATA_W   = 512,
  parameter logic [3:0]  AGENT_ID = 4'h0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [35:0]       req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic [35:0]       ring_addr_in,
  input  logic [DATA_W-1:0] ring_data_in,
  input  logic [3:0]        ring_id_in,
  input  logic [2:0]        ring_type_in,
  output logic              ring_overwrite,
  output logic [35:0]       ring_addr_out,
  output logic [DATA_W-1:0] ring_data_out,
  output logic [3:0]        ring_id_out,
  output logic [2:0]        ring_type_out
);

  localparam logic [2:0] TypeEmpty  = 3'd0;
  localparam logic [2:0] TypeRdReq  = 3'd1;
  localparam logic [2:0] TypeWrReq  = 3'd2;
  localparam logic [2:0] TypeRdResp = 3'd3;
  localparam logic [2:0] TypeWrAck  = 3'd4;

  localparam int unsigned       TimerW    = $clog2(TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitSlot,
    StWaitResp
  } state_e;

  state_e              state_q, state_d;
  logic [35:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          type_q, type_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic                match;

  // A response addressed to us, whether expected or left over from an abandoned request.
  assign match = ((ring_type_in == TypeRdResp) || (ring_type_in == TypeWrAck)) &&
                 (ring_id_in == AGENT_ID);

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      type_q       <= TypeEmpty;
      timer_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      type_q       <= type_d;
      timer_q      <= timer_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    type_d         = type_q;
    timer_d        = timer_q;
    resp_data_d    = resp_data_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    ring_overwrite = 1'b0;
    ring_addr_out  = '0;
    ring_data_out  = '0;
    ring_id_out    = '0;
    ring_type_out  = TypeEmpty;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          type_d  = req_write ? TypeWrReq : TypeRdReq;
          state_d = StWaitSlot;
        end
        // Drain a late response silently by replacing it with an empty slot.
        if (match) begin
          ring_overwrite = 1'b1;
        end
      end

      StWaitSlot: begin
        if ((ring_type_in == TypeEmpty) || match) begin
          ring_overwrite = 1'b1;
          ring_addr_out  = addr_q;
          ring_data_out  = data_q;
          ring_id_out    = AGENT_ID;
          ring_type_out  = type_q;
          timer_d        = '0;
          state_d        = StWaitResp;
        end
      end

      StWaitResp: begin
        if (match) begin
          ring_overwrite = 1'b1;
          resp_data_d    = ring_data_in;
          resp_valid_d   = 1'b1;
          state_d        = StIdle;
        end else if (timer_q == TimerLast) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The pass-through slot address is never needed: replacements carry their own address.
  logic unused_ring_addr;
  assign unused_ring_addr = ^ring_addr_in;

endmodule

// File: tb/tb_ring_request_agent.sv
// Directed, table-driven bench for ring_request_agent (AGENT_ID=A, TIMEOUT=8, 64-bit data).
module tb_ring_request_agent;

  localparam int unsigned DW = 64;
  localparam logic [3:0]  ID = 4'hA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [35:0]   req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready, resp_valid, resp_err, ring_overwrite;
  logic [DW-1:0] resp_data, ring_data_out;
  logic [35:0]   ring_addr_in = '0, ring_addr_out;
  logic [DW-1:0] ring_data_in = '0;
  logic [3:0]    ring_id_in = '0, ring_id_out;
  logic [2:0]    ring_type_in = '0, ring_type_out;

  int checks = 0;
  int failures = 0;
  int row = 0;

  always #5 clk = ~clk;

  ring_request_agent #(.DATA_W(DW), .AGENT_ID(ID), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .ring_addr_in(ring_addr_in), .ring_data_in(ring_data_in),
    .ring_id_in(ring_id_in), .ring_type_in(ring_type_in),
    .ring_overwrite(ring_overwrite), .ring_addr_out(ring_addr_out),
    .ring_data_out(ring_data_out), .ring_id_out(ring_id_out), .ring_type_out(ring_type_out)
  );

  typedef struct {
    logic rst, rv, rw; logic [35:0] raddr; logic [63:0] rdata;
    logic [2:0] t; logic [3:0] id; logic [35:0] a; logic [63:0] d;
    logic e_rdy, e_ov; logic [2:0] e_t; logic [3:0] e_id; logic [35:0] e_a; logic [63:0] e_d;
    logic e_rv, e_re; logic [63:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, rv, rw, input logic [35:0] raddr, input logic [63:0] rdata,
                     input logic [2:0] t, input logic [3:0] id, input logic [35:0] a,
                     input logic [63:0] d, input logic e_rdy, e_ov, input logic [2:0] e_t,
                     input logic [3:0] e_id, input logic [35:0] e_a, input logic [63:0] e_d,
                     input logic e_rv, e_re, input logic [63:0] e_rd);
    vec_t v;
    v.rst = r; v.rv = rv; v.rw = rw; v.raddr = raddr; v.rdata = rdata;
    v.t = t; v.id = id; v.a = a; v.d = d;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_t = e_t; v.e_id = e_id; v.e_a = e_a; v.e_d = e_d;
    v.e_rv = e_rv; v.e_re = e_re; v.e_rd = e_rd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic set_ring(input logic [2:0] t, input logic [3:0] id, input logic [35:0] a,
                          input logic [63:0] d);
    ring_type_in = t; ring_id_in = id; ring_addr_in = a; ring_data_in = d;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; req_valid = v.rv; req_write = v.rw; req_addr = v.raddr; req_data = v.rdata;
    set_ring(v.t, v.id, v.a, v.d);
    #1;
    chk("req_ready", 64'(req_ready), 64'(v.e_rdy));
    chk("ring_overwrite", 64'(ring_overwrite), 64'(v.e_ov));
    chk("ring_type_out", 64'(ring_type_out), 64'(v.e_t));
    chk("ring_id_out", 64'(ring_id_out), 64'(v.e_id));
    chk("ring_addr_out", 64'(ring_addr_out), 64'(v.e_a));
    chk("ring_data_out", ring_data_out, v.e_d);
    chk("resp_valid", 64'(resp_valid), 64'(v.e_rv));
    chk("resp_err", 64'(resp_err), 64'(v.e_re));
    chk("resp_data", resp_data, v.e_rd);
  endtask

  initial begin
    int k;
    logic got;

    // rst rv rw raddr rdata | ring t id a d | rdy ov t id a d | resp_valid err data
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // read, injected into the empty slot the cycle after acceptance
    add(0, 1, 0, 36'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ID, 36'h100, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, ID, 0, 64'hDEAD, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 64'hDEAD);
    // write against a busy ring
    add(0, 1, 1, 36'h2_0000_0040, 64'h1234_5678, 1, 5, 36'h55, 64'h66,
        1, 0, 0, 0, 0, 0, 0, 0, 64'hDEAD);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 0, 1, 5, 36'h55, 64'h66, 0, 0, 0, 0, 0, 0, 0, 0, 64'hDEAD);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, ID, 36'h2_0000_0040, 64'h1234_5678,
        0, 0, 64'hDEAD);
    // foreign response and foreign request pass untouched
    add(0, 0, 0, 0, 0, 3, 3, 36'h33, 64'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 64'hDEAD);
    add(0, 0, 0, 0, 0, 1, 3, 36'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hDEAD);
    add(0, 0, 0, 0, 0, 4, ID, 0, 64'h77, 0, 1, 0, 0, 0, 0, 0, 0, 64'hDEAD);
    // new request accepted in the resp_valid cycle, then timeout
    add(0, 1, 0, 36'h300, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 64'h77);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ID, 36'h300, 0, 0, 0, 64'h77);
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h77);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 64'h77);
    // late ack drained in idle, no response pulse, data not captured
    add(0, 0, 0, 0, 0, 4, ID, 36'h12, 64'h99, 1, 1, 0, 0, 0, 0, 0, 0, 64'h77);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64'h77);
    // match on the last timer cycle wins over the timeout
    add(0, 1, 0, 36'h400, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64'h77);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ID, 36'h400, 0, 0, 0, 64'h77);
    for (int i = 0; i < 7; i++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h77);
    add(0, 0, 0, 0, 0, 3, ID, 0, 64'hAB, 0, 1, 0, 0, 0, 0, 0, 0, 64'h77);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 64'hAB);
    // stale response slot reused for a new write
    add(0, 1, 1, 36'h500, 64'h5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64'hAB);
    add(0, 0, 0, 0, 0, 3, ID, 36'h9, 64'hCC, 0, 1, 2, ID, 36'h500, 64'h5, 0, 0, 64'hAB);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hAB);

    foreach (tbl[i]) begin
      row = i;
      apply(tbl[i]);
    end

    // Asynchronous reset while waiting for the response: takes effect without a clock edge.
    row = 1000;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_overwrite", 64'(ring_overwrite), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Late ack for the abandoned request is drained.
    row = 1001;
    @(negedge clk);
    set_ring(3'd4, ID, 36'h0, 64'h55);
    #1;
    chk("drain_overwrite", 64'(ring_overwrite), 64'd1);
    chk("drain_type", 64'(ring_type_out), 64'd0);
    @(negedge clk);
    set_ring(3'd0, 4'h0, 36'h0, 64'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h600; req_data = '0;
    #1;
    chk("drain_no_resp", 64'(resp_valid), 64'd0);

    // Request after reset: three busy slots, then inject into the first empty one.
    row = 1002;
    got = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (i < 3) set_ring(3'd2, 4'h7, 36'h77, 64'h7);
      else set_ring(3'd0, 4'h0, 36'h0, 64'h0);
      #1;
      if (ring_overwrite) begin
        got = 1'b1;
        k = i;
        break;
      end
    end
    chk("post_rst_inject_seen", 64'(got), 64'd1);
    chk("post_rst_inject_cycle", 64'(k), 64'd3);
    chk("post_rst_inject_type", 64'(ring_type_out), 64'd1);
    chk("post_rst_inject_addr", 64'(ring_addr_out), 64'h600);

    @(negedge clk);
    set_ring(3'd3, ID, 36'h0, 64'h600D);
    #1;
    chk("post_rst_remove", 64'(ring_overwrite), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_ring(3'd0, 4'h0, 36'h0, 64'h0);
      #1;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("post_rst_resp_seen", 64'(got), 64'd1);
    chk("post_rst_resp_err", 64'(resp_err), 64'd0);
    chk("post_rst_resp_data", resp_data, 64'h600D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
